// File: rtl/button_reader_pkg.sv
// rtl/button_reader_pkg.sv - shared constants and helpers for the button_reader peripheral
package button_reader_pkg;

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_EDGE  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_RSVD  = 2'd3;

  localparam int DATA_W = 32;

  // Width of the per-key debounce counter; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - one pushbutton: 2-flop synchroniser, polarity fix, debounce counter, press pulse
module key_debouncer
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic stable,
  output logic press
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic            RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Internal level is 1 when pressed, whatever the board polarity.
  assign level = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Acceptance of a new pressed level is the press event.
  assign press = level & ~stable & (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= RELEASED;
      sync2  <= RELEASED;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      if (level == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_reader.sv
// rtl/button_reader.sv - memory-mapped pushbutton reader: STATE, EDGE (W1C), optional MASK/irq under BUTTON_IRQ_EN
module button_reader
  import button_reader_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [N_KEYS-1:0] keys
`ifdef BUTTON_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] edge_q;
  logic [N_KEYS-1:0] edge_clr;
  logic [DATA_W-1:0] rd_mux;

  genvar k;
  generate
    for (k = 0; k < N_KEYS; k++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .key   (keys[k]),
        .stable(stable[k]),
        .press (press[k])
      );
    end
  endgenerate

  generate
    if (N_KEYS < DATA_W) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[DATA_W-1:N_KEYS];
    end
  endgenerate

  assign edge_clr = (write && address == ADDR_EDGE) ? writedata[N_KEYS-1:0] : '0;

`ifdef BUTTON_IRQ_EN
  logic [N_KEYS-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (write && address == ADDR_MASK) mask_q <= writedata[N_KEYS-1:0];
      irq <= |(edge_q & mask_q);
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATE: rd_mux[N_KEYS-1:0] = stable;
      ADDR_EDGE:  rd_mux[N_KEYS-1:0] = edge_q;
`ifdef BUTTON_IRQ_EN
      ADDR_MASK:  rd_mux[N_KEYS-1:0] = mask_q;
`endif
      default:    rd_mux = '0;
    endcase
  end

  // A press landing on the same edge as its W1C keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q   <= '0;
      readdata <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | press;
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - directed self-checking bench for button_reader (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
module tb_button_reader;
  import button_reader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  keys;
`ifdef BUTTON_IRQ_EN
  logic        irq;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  button_reader #(
    .N_KEYS         (4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .read     (read),
    .readdata (readdata),
    .write    (write),
    .writedata(writedata),
    .keys     (keys)
`ifdef BUTTON_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick(1);
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick(1);
    write     = 1'b0;
    writedata = '0;
  endtask

  task automatic test_reset;
    compared++;
    if (readdata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
    end
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      compared++;
      if (rd !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_read_addr%0d: got %h expected %h", a, rd, 32'h0);
      end
    end
`ifdef BUTTON_IRQ_EN
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
`endif
  endtask

  task automatic test_press;
    keys = 4'b1110;
    tick(5);
    bus_read(ADDR_STATE, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL press_state_early: got %h expected %h", rd, 32'h0);
    end
    bus_read(ADDR_STATE, rd);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL press_state: got %h expected %h", rd, 32'h1);
    end
    bus_read(ADDR_EDGE, rd);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL press_edge: got %h expected %h", rd, 32'h1);
    end
    bus_write(ADDR_STATE, 32'hF);
    bus_read(ADDR_STATE, rd);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL state_write_ignored: got %h expected %h", rd, 32'h1);
    end
    keys = 4'b1111;
    tick(8);
    bus_read(ADDR_STATE, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL release_state: got %h expected %h", rd, 32'h0);
    end
    bus_read(ADDR_EDGE, rd);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL release_no_event: got %h expected %h", rd, 32'h1);
    end
    bus_write(ADDR_EDGE, 32'h1);
  endtask

  task automatic test_glitch;
    keys = 4'b1011;
    tick(2);
    keys = 4'b1111;
    tick(10);
    bus_read(ADDR_STATE, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL glitch_state: got %h expected %h", rd, 32'h0);
    end
    bus_read(ADDR_EDGE, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL glitch_edge: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_w1c;
    keys = 4'b1010;
    tick(8);
    bus_read(ADDR_EDGE, rd);
    compared++;
    if (rd !== 32'h5) begin
      mismatched++;
      $display("FAIL w1c_setup_edge: got %h expected %h", rd, 32'h5);
    end
    bus_write(ADDR_EDGE, 32'h1);
    bus_read(ADDR_EDGE, rd);
    compared++;
    if (rd !== 32'h4) begin
      mismatched++;
      $display("FAIL w1c_partial: got %h expected %h", rd, 32'h4);
    end
    keys = 4'b1111;
    tick(8);
    bus_write(ADDR_EDGE, 32'h4);
    bus_read(ADDR_EDGE, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL w1c_all_clear: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_set_wins;
    keys = 4'b1110;
    tick(5);
    bus_write(ADDR_EDGE, 32'h1);
    bus_read(ADDR_EDGE, rd);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL set_wins_edge: got %h expected %h", rd, 32'h1);
    end
    address   = ADDR_EDGE;
    writedata = 32'h1;
    read      = 1'b1;
    write     = 1'b1;
    tick(1);
    read      = 1'b0;
    write     = 1'b0;
    compared++;
    if (readdata !== 32'h1) begin
      mismatched++;
      $display("FAIL read_write_pre_clear: got %h expected %h", readdata, 32'h1);
    end
    bus_read(ADDR_EDGE, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL read_write_cleared: got %h expected %h", rd, 32'h0);
    end
    keys = 4'b1111;
    tick(8);
  endtask

  task automatic test_mask_rsvd;
    bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
    bus_read(ADDR_RSVD, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL rsvd_read: got %h expected %h", rd, 32'h0);
    end
`ifdef BUTTON_IRQ_EN
    bus_write(ADDR_MASK, 32'h2);
    bus_read(ADDR_MASK, rd);
    compared++;
    if (rd !== 32'h2) begin
      mismatched++;
      $display("FAIL mask_read: got %h expected %h", rd, 32'h2);
    end
`else
    bus_write(ADDR_MASK, 32'hF);
    bus_read(ADDR_MASK, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL mask_absent_read: got %h expected %h", rd, 32'h0);
    end
`endif
  endtask

`ifdef BUTTON_IRQ_EN
  task automatic test_irq;
    keys = 4'b1101;
    tick(6);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("FAIL irq_before_rise: got %b expected 0", irq);
    end
    tick(1);
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("FAIL irq_rise: got %b expected 1", irq);
    end
    bus_write(ADDR_EDGE, 32'h2);
    tick(1);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("FAIL irq_fall: got %b expected 0", irq);
    end
    keys = 4'b0111;
    tick(8);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("FAIL irq_masked_key3: got %b expected 0", irq);
    end
    bus_read(ADDR_EDGE, rd);
    compared++;
    if (rd !== 32'h8) begin
      mismatched++;
      $display("FAIL irq_key3_edge: got %h expected %h", rd, 32'h8);
    end
    keys = 4'b1111;
    tick(8);
    bus_write(ADDR_EDGE, 32'hF);
  endtask
`endif

  task automatic test_reset_mid_debounce;
    keys = 4'b1110;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(5);
    bus_read(ADDR_STATE, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL rst_mid_state_early: got %h expected %h", rd, 32'h0);
    end
    bus_read(ADDR_STATE, rd);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL rst_mid_state: got %h expected %h", rd, 32'h1);
    end
    bus_read(ADDR_EDGE, rd);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL rst_mid_edge: got %h expected %h", rd, 32'h1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    address   = '0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = '0;
    keys      = 4'b1111;
    tick(2);
    reset     = 1'b0;
    tick(1);

    test_reset();
    test_press();
    test_glitch();
    test_w1c();
    test_set_wins();
    test_mask_rsvd();
`ifdef BUTTON_IRQ_EN
    test_irq();
`endif
    test_reset_mid_debounce();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
